// File: rtl/divider_pkg.sv
// Shared types and helpers for the divider_qr restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Bits needed to hold an iteration count of 0..width.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring shift-subtract step: shift in the next dividend bit, subtract the divisor if it fits.
module divider_step
  import divider_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_rem,
  output logic             o_qbit
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH:0]   w_div_ext;

  // Compare at full shifted width so the partial remainder MSB takes part in the decision.
  assign w_shift   = {i_rem, i_bit};
  assign w_div_ext = {1'b0, i_divisor};
  assign o_qbit    = (w_shift >= {1'b0, w_div_ext});
  assign o_rem     = o_qbit ? (w_shift[WIDTH:0] - w_div_ext) : w_shift[WIDTH:0];

endmodule

// File: rtl/divider_qr.sv
// Unsigned iterative restoring divider with joined AXI-stream operand inputs and a quotient/remainder output.
// Optional divide-by-zero flag on output_tuser when DIVIDER_DIVZERO_FLAG_EN is defined.
module divider_qr
  import divider_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input_dividen_tdata,
  input  logic             input_dividen_tvalid,
  output logic             input_dividen_tready,
  input  logic [WIDTH-1:0] input_divisor_tdata,
  input  logic             input_divisor_tvalid,
  output logic             input_divisor_tready,
  output logic [WIDTH-1:0] output_tdata,
  output logic [WIDTH-1:0] output_remainder_tdata,
  output logic             output_tvalid,
  input  logic             output_tready
`ifdef DIVIDER_DIVZERO_FLAG_EN
  ,
  output logic             output_tuser
`endif
);

  localparam int CW = cnt_w(WIDTH);

  div_state_t       r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo, r_div;
  logic             r_tvalid;
  logic [WIDTH-1:0] r_q_out, r_r_out;
  logic [WIDTH:0]   w_rem_nxt;
  logic             w_qbit, w_rdy, w_capture, w_zero, w_last, w_out_hs;
`ifdef DIVIDER_DIVZERO_FLAG_EN
  logic             r_tuser;
`endif

  assign w_rdy     = (r_state == IDLE);
  assign w_capture = w_rdy & input_dividen_tvalid & input_divisor_tvalid;
  assign w_zero    = (input_divisor_tdata == '0);
  assign w_last    = (r_cnt == CW'(1));
  assign w_out_hs  = r_tvalid & output_tready;

  divider_step #(.WIDTH(WIDTH)) u_step (
    .i_rem    (r_rem),
    .i_bit    (r_quo[WIDTH-1]),
    .i_divisor(r_div),
    .o_rem    (w_rem_nxt),
    .o_qbit   (w_qbit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_capture) w_next = w_zero ? DONE : CALC;
      CALC:    if (w_last) w_next = DONE;
      DONE:    if (w_out_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Control and visible outputs; result registers only change when DONE is entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_tvalid <= 1'b0;
      r_q_out  <= '0;
      r_r_out  <= '0;
`ifdef DIVIDER_DIVZERO_FLAG_EN
      r_tuser  <= 1'b0;
`endif
    end else begin
      if (w_capture && !w_zero) r_cnt <= CW'(WIDTH);
      else if (r_state == CALC) r_cnt <= r_cnt - CW'(1);

      if (w_capture && w_zero) begin
        r_tvalid <= 1'b1;
        r_q_out  <= '1;
        r_r_out  <= input_dividen_tdata;
`ifdef DIVIDER_DIVZERO_FLAG_EN
        r_tuser  <= 1'b1;
`endif
      end else if (r_state == CALC && w_last) begin
        r_tvalid <= 1'b1;
        r_q_out  <= {r_quo[WIDTH-2:0], w_qbit};
        r_r_out  <= w_rem_nxt[WIDTH-1:0];
`ifdef DIVIDER_DIVZERO_FLAG_EN
        r_tuser  <= 1'b0;
`endif
      end else if (w_out_hs) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  // Working datapath is always re-initialised on capture, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_rem <= '0;
      r_quo <= input_dividen_tdata;
      r_div <= input_divisor_tdata;
    end else if (r_state == CALC) begin
      r_rem <= w_rem_nxt;
      r_quo <= {r_quo[WIDTH-2:0], w_qbit};
    end
  end

  assign input_dividen_tready   = w_rdy;
  assign input_divisor_tready   = w_rdy;
  assign output_tdata           = r_q_out;
  assign output_remainder_tdata = r_r_out;
  assign output_tvalid          = r_tvalid;
`ifdef DIVIDER_DIVZERO_FLAG_EN
  assign output_tuser           = r_tuser;
`endif

endmodule

// File: tb/tb_divider_qr.sv
// Directed bench for divider_qr: a 64-bit and an 8-bit instance driven from one linear step sequence.
module tb_divider_qr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [63:0] a64, b64, q64, r64;
  logic        va64, vb64, ra64, rb64, ov64, ot64;
  logic [7:0]  a8, b8, q8, r8;
  logic        va8, vb8, ra8, rb8, ov8, ot8;
`ifdef DIVIDER_DIVZERO_FLAG_EN
  logic        tu64, tu8;
`endif

  int n_chk = 0;
  int n_err = 0;

  divider_qr #(.WIDTH(64)) dut64 (
    .clk                   (clk),
    .rst                   (rst),
    .input_dividen_tdata   (a64),
    .input_dividen_tvalid  (va64),
    .input_dividen_tready  (ra64),
    .input_divisor_tdata   (b64),
    .input_divisor_tvalid  (vb64),
    .input_divisor_tready  (rb64),
    .output_tdata          (q64),
    .output_remainder_tdata(r64),
    .output_tvalid         (ov64),
    .output_tready         (ot64)
`ifdef DIVIDER_DIVZERO_FLAG_EN
    ,
    .output_tuser          (tu64)
`endif
  );

  divider_qr #(.WIDTH(8)) dut8 (
    .clk                   (clk),
    .rst                   (rst),
    .input_dividen_tdata   (a8),
    .input_dividen_tvalid  (va8),
    .input_dividen_tready  (ra8),
    .input_divisor_tdata   (b8),
    .input_divisor_tvalid  (vb8),
    .input_divisor_tready  (rb8),
    .output_tdata          (q8),
    .output_remainder_tdata(r8),
    .output_tvalid         (ov8),
    .output_tready         (ot8)
`ifdef DIVIDER_DIVZERO_FLAG_EN
    ,
    .output_tuser          (tu8)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Entered at posedge+1 with the 64-bit DUT idle; leaves it idle at posedge+1.
  task automatic run64(input logic [63:0] a, input logic [63:0] b, input logic [63:0] eq,
                       input logic [63:0] er, input int elat, input int hold, input string tag);
    int lat = 0;
    a64 = a; b64 = b; va64 = 1'b1; vb64 = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_rdy_busy"}, {62'd0, ra64, rb64}, 64'd0);
    a64 = ~a; b64 = ~b;
    if (!ov64) begin @(posedge clk); #1; lat = 1; end
    va64 = 1'b0; vb64 = 1'b0;
    while (!ov64 && lat < 400) begin @(posedge clk); #1; lat++; end
    chk({tag, "_latency"}, 64'(lat), 64'(elat));
    chk({tag, "_quot"}, q64, eq);
    chk({tag, "_rem"}, r64, er);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold"}, {ov64, ra64, rb64, q64[60:0]}, {3'b100, eq[60:0]});
      chk({tag, "_hold_rem"}, r64, er);
    end
    ot64 = 1'b1; va64 = 1'b1; vb64 = 1'b1; a64 = 64'd99; b64 = 64'd3;
    @(posedge clk); #1;
    ot64 = 1'b0;
    chk({tag, "_tvalid_drop"}, {63'd0, ov64}, 64'd0);
    chk({tag, "_rdy_after_hs"}, {62'd0, ra64, rb64}, 64'd3);
    va64 = 1'b0; vb64 = 1'b0;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                      input logic [7:0] er, input int elat, input int hold,
                      input logic etu, input string tag);
    int lat = 0;
    a8 = a; b8 = b; va8 = 1'b1; vb8 = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_rdy_busy"}, {62'd0, ra8, rb8}, 64'd0);
    a8 = ~a; b8 = ~b;
    if (!ov8) begin @(posedge clk); #1; lat = 1; end
    va8 = 1'b0; vb8 = 1'b0;
    while (!ov8 && lat < 100) begin @(posedge clk); #1; lat++; end
    chk({tag, "_latency"}, 64'(lat), 64'(elat));
    chk({tag, "_quot"}, 64'(q8), 64'(eq));
    chk({tag, "_rem"}, 64'(r8), 64'(er));
`ifdef DIVIDER_DIVZERO_FLAG_EN
    chk({tag, "_tuser"}, {63'd0, tu8}, {63'd0, etu});
`else
    if (etu) chk({tag, "_dz_quot_ones"}, 64'(q8), 64'hFF);
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold"}, {43'd0, ov8, ra8, rb8, q8, r8}, {43'd0, 3'b100, eq, er});
    end
    ot8 = 1'b1; va8 = 1'b1; vb8 = 1'b1; a8 = 8'd9; b8 = 8'd3;
    @(posedge clk); #1;
    ot8 = 1'b0;
    chk({tag, "_tvalid_drop"}, {63'd0, ov8}, 64'd0);
    chk({tag, "_rdy_after_hs"}, {62'd0, ra8, rb8}, 64'd3);
    va8 = 1'b0; vb8 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst = 1'b1;
    a64 = '0; b64 = '0; va64 = 1'b0; vb64 = 1'b0; ot64 = 1'b0;
    a8  = '0; b8  = '0; va8  = 1'b0; vb8  = 1'b0; ot8  = 1'b0;
    #1 rst = 1'b0;
    #1;
    // Reset state of both instances.
    chk("reset64_outs", {63'd0, ov64} | q64 | r64, 64'd0);
    chk("reset8_outs", {47'd0, ov8, q8, r8}, 64'd0);
`ifdef DIVIDER_DIVZERO_FLAG_EN
    chk("reset_tuser", {62'd0, tu64, tu8}, 64'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("rdy_after_rst", {60'd0, ra64, rb64, ra8, rb8}, 64'hF);

    // Dividend alone must not be consumed.
    a64 = 64'd100; b64 = 64'd7; va64 = 1'b1; vb64 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("single_valid_rdy", {61'd0, ov64, ra64, rb64}, 64'd3);
    end
    run64(64'd100, 64'd7, 64'd14, 64'd2, 64, 0, "d100_7");
    run64(64'd5, 64'd9, 64'd0, 64'd5, 64, 0, "d5_9");
    run64(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64, 0, "dmax_1");
    run64(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64, 0, "dmaxm1_max");
    run64(64'd3000000026, 64'd1000000007, 64'd3, 64'd5, 64, 2, "d3e9");
    run64(64'h8000_0000_0000_0000, 64'd3, 64'd3074457345618258602, 64'd2, 64, 0, "d2p63_3");

    run8(8'd255, 8'd0, 8'd255, 8'd255, 0, 3, 1'b1, "d8_255_0");
    run8(8'd255, 8'd16, 8'd15, 8'd15, 8, 20, 1'b0, "d8_255_16");
    run8(8'd200, 8'd7, 8'd28, 8'd4, 8, 0, 1'b0, "d8_200_7");

    // Abort a 64-bit division mid-CALC with an asynchronous reset.
    a64 = 64'd12345; b64 = 64'd67; va64 = 1'b1; vb64 = 1'b1;
    @(posedge clk); #1;
    va64 = 1'b0; vb64 = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_outs_zero", {63'd0, ov64} | q64 | r64, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (ov64) seen = 1'b1;
    end
    chk("abort_no_result", {63'd0, seen}, 64'd0);
    chk("abort_rdy", {62'd0, ra64, rb64}, 64'd3);
    run64(64'd100, 64'd7, 64'd14, 64'd2, 64, 0, "post_abort");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/divider_qr.md
DIVIDER_QR -- requirements
Module: divider_qr

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width in bits (legal range 8..256).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have port input_dividen_tdata  input  WIDTH  dividend.
REQ-005 SHALL have port input_dividen_tvalid  input  1  dividend valid.
REQ-006 SHALL have port input_dividen_tready  output  1  dividend accepted.
REQ-007 SHALL have port input_divisor_tdata  input  WIDTH  divisor.
REQ-008 SHALL have port input_divisor_tvalid  input  1  divisor valid.
REQ-009 SHALL have port input_divisor_tready  output  1  divisor accepted.
REQ-010 SHALL have port output_tdata  output  WIDTH  quotient.
REQ-011 SHALL have port output_remainder_tdata  output  WIDTH  remainder.
REQ-012 SHALL have port output_tvalid  output  1  result valid.
REQ-013 SHALL have port output_tready  input  1  downstream ready.
REQ-014 SHALL have port output_tuser  output  1  divide-by-zero flag, present only with DIVIDER_DIVZERO_FLAG_EN.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE.
REQ-016 SHALL drive both input tready signals high only in IDLE, identically.
REQ-017 SHALL capture operands only on an edge where both tvalids and both treadys are high (join); a single tvalid SHALL not be consumed.
REQ-018 SHALL move IDLE->CALC on capture with non-zero divisor, loading an iteration counter with WIDTH.
REQ-019 SHALL perform one restoring shift-subtract step per CALC cycle, using a WIDTH+1-bit partial remainder, unsigned arithmetic.
REQ-020 SHALL move CALC->DONE on the edge completing the WIDTH-th step; output_tvalid high exactly WIDTH cycles after the capture edge.
REQ-021 SHALL on capture with divisor zero move IDLE->DONE directly: quotient all-ones, remainder = dividend, output_tvalid high 1 cycle after capture.
REQ-022 SHALL hold output_tdata, output_remainder_tdata, output_tuser stable while output_tvalid high and output_tready low.
REQ-023 SHALL move DONE->IDLE on the edge where output_tvalid and output_tready are both high; output_tvalid low next cycle.
REQ-024 SHALL not accept new operands in the DONE->IDLE handshake cycle; throughput one result per WIDTH+2 cycles minimum.
REQ-025 SHALL ignore input tvalid/tdata changes during CALC and DONE.
REQ-026 SHALL keep output data registers unchanged outside DONE-entry updates (no glitching to intermediate values on outputs).

Reset
REQ-027 SHALL on rst low, asynchronously, force state IDLE, counter 0, output_tvalid 0, output_tdata 0, output_remainder_tdata 0, output_tuser 0.
REQ-028 SHALL abort any in-progress division on reset mid-CALC or mid-DONE; no result emitted for it.
REQ-029 SHALL drive input treadys high the first cycle after rst deasserts.

Configuration
REQ-030 SHALL with macro DIVIDER_DIVZERO_FLAG_EN defined add output_tuser, high with a divide-by-zero result and low otherwise.
REQ-031 SHALL without DIVIDER_DIVZERO_FLAG_EN omit output_tuser; divide-by-zero values of REQ-021 unchanged.

Structure
REQ-032 SHALL place the FSM state enum and a counter-width function ($clog2(WIDTH+1)) in shared package divider_pkg.
REQ-033 SHALL factor one restoring step (partial remainder, divisor in; next remainder, quotient bit out) into combinational sub-module divider_step.

Verification
REQ-034 SHALL cover WIDTH=64, 100 / 7 -> quotient 14, remainder 2, output_tvalid 64 cycles after capture.
REQ-035 SHALL cover WIDTH=64, 5 / 9 -> quotient 0, remainder 5; and 2^64-1 / 1 -> quotient 2^64-1, remainder 0.
REQ-036 SHALL cover WIDTH=8, 255 / 0 -> quotient 255, remainder 255, tvalid after 1 cycle, output_tuser 1 when DIVIDER_DIVZERO_FLAG_EN defined.
REQ-037 SHALL cover WIDTH=8, 255 / 16 with output_tready low 20 cycles -> quotient 15, remainder 15 held stable, input treadys low throughout.
REQ-038 SHALL cover rst low at cycle 10 of a 64-bit division -> all outputs 0 immediately, no result after rst release, next 100 / 7 correct.
REQ-039 SHALL cover dividend tvalid high with divisor tvalid low for 5 cycles -> no capture, treadys stay high, capture on the cycle divisor tvalid rises.
